ahb_apb_bridge: RTL and testbench
=================================

// Module: ahb_apb_bridge
// PURPOSE
//   Single-clock AHB-Lite slave to APB master bridge. Sits directly upstream of apb_ram and other APB slaves.
//   Converts each AHB NONSEQ/SEQ transfer into one APB SETUP+ACCESS transaction.
//   Stretches the AHB data phase with hreadyout and maps pslverr onto a two-cycle AHB ERROR response.
// PARAMETERS
//   AWIDTH  10        address width (bits), both sides
//   DSIZE   2         data size, log2 of bus bytes (fixed per instance)
//   DBYTES  1<<DSIZE  hidden: data bytes
//   DWIDTH  DBYTES*8  hidden: data width (bits)
// PORTS
//   hclk       in   1       clock, shared by AHB and APB sides (pclk of the slave = hclk)
//   hresetn    in   1       reset, synchronous, active-low
//   hsel       in   1       AHB slave select
//   hready     in   1       AHB bus ready (previous data phase done)
//   htrans     in   2       AHB transfer type; only bit 1 used (NONSEQ/SEQ)
//   hsize      in   3       AHB transfer size, log2 bytes
//   hprot      in   4       AHB protection
//   hwrite     in   1       1 = write
//   haddr      in   AWIDTH  AHB byte address
//   hwdata     in   DWIDTH  AHB write data (data phase)
//   hrdata     out  DWIDTH  AHB read data, registered
//   hreadyout  out  1       AHB slave ready
//   hresp      out  1       AHB response, 1 = ERROR
//   psel       out  1       APB select
//   penable    out  1       APB enable
//   pprot      out  3       APB protection
//   pwrite     out  1       APB write
//   paddr      out  AWIDTH  APB byte address, registered
//   pstrb      out  DBYTES  APB byte strobes, registered
//   pwdata     out  DWIDTH  APB write data
//   prdata     in   DWIDTH  APB read data
//   pready     in   1       APB ready
//   pslverr    in   1       APB slave error
// BEHAVIOUR
//   - Reset: state IDLE, psel=0, penable=0, hreadyout=1, hresp=0, hrdata=0, paddr=0, pstrb=0, pwrite=0, pprot=0.
//   - Reset asserted in any state, including mid-ACCESS, forces the reset values on the next edge; no APB completion.
//   - accept = hsel & hready & htrans[1], evaluated only in IDLE and ERR2; otherwise ignored.
//   - Accept registers paddr<=haddr, pwrite<=hwrite, and pprot<={~hprot[0], 1'b0, hprot[1]}.
//   - Accept also registers pstrb: write -> bits [a, a+2^hsize-1] set, a = haddr[DSIZE-1:0]; read -> all 0.
//   - IDLE/BUSY transfers and hsel=0 return OKAY with zero wait states (hreadyout already 1).
//   - Illegal transfer: hsize > DSIZE, or haddr not aligned to 2^hsize. Accepting one goes straight to ERR1.
//     No APB access is made for an illegal transfer.
//   - pwdata = hwdata combinationally; the AHB master holds hwdata stable while hreadyout=0.
//   - FSM, with outputs per state:
//       IDLE    hreadyout=1 hresp=0 psel=0 penable=0. accept legal -> SETUP; accept illegal -> ERR1.
//       SETUP   hreadyout=0 psel=1 penable=0. Always -> ACCESS.
//       ACCESS  hreadyout=0 psel=1 penable=1. pready=0 -> stay; all APB outputs held stable.
//               pready & !pslverr -> IDLE; hrdata<=prdata if read.
//               pready & pslverr -> ERR1; hrdata unchanged.
//       ERR1    hreadyout=0 hresp=1 psel=0. Always -> ERR2.
//       ERR2    hreadyout=1 hresp=1. accept legal -> SETUP; accept illegal -> ERR1; else -> IDLE.
//   - Latency with pready=1: address phase T0, SETUP T1, ACCESS T2, hreadyout=1 in T3 (2 wait states).
//     Each cycle of pready=0 adds one wait state.
//   - Back-to-back: a transfer pipelined into the completing cycle (IDLE at T3) is accepted there; next SETUP at T4.
//   - hrdata holds its last read value across writes, errors and idle cycles.
// TESTING
//   - DWIDTH=32, apb_ram downstream. Write hsize=2 haddr=0x010 hwdata=0xDEADBEEF.
//     -> pstrb=4'b1111, paddr=0x010, hreadyout low 2 cycles. A later read returns hrdata=0xDEADBEEF.
//   - Byte write hsize=0 haddr=0x00D hwdata=0x0000AB00 -> pstrb=4'b0010. Readback word = 0xDEADABEF (prior test data).
//   - Read with pready held low 3 cycles in ACCESS -> psel/penable/paddr stable, hreadyout low 5 cycles.
//     hrdata = prdata sampled on the pready cycle.
//   - pslverr=1 with pready=1 -> hresp=1,hreadyout=0 then hresp=1,hreadyout=1, then IDLE OKAY. hrdata unchanged.
//   - hsize=3 (or hsize=2 haddr=0x002) -> ERR1/ERR2 error response, psel never asserted.
//   - hresetn=0 for one cycle during ACCESS -> next edge psel=0, penable=0, hreadyout=1, hrdata=0.
//     A new write after reset completes normally.

Source files
------------

// File: rtl/ahb_apb_bridge_if.sv
// Bus bundle between an AHB-Lite master and an APB slave, with the bridge sitting in the middle.
// slave = bridge view (AHB slave, APB master); master = environment view (AHB master, APB slave).
interface ahb_apb_bridge_if #(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned DSIZE  = 2
);
  localparam int unsigned DBYTES = 1 << DSIZE;
  localparam int unsigned DWIDTH = DBYTES * 8;

  // AHB side
  logic              hsel;
  logic              hready;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [3:0]        hprot;
  logic              hwrite;
  logic [AWIDTH-1:0] haddr;
  logic [DWIDTH-1:0] hwdata;
  logic [DWIDTH-1:0] hrdata;
  logic              hreadyout;
  logic              hresp;

  // APB side
  logic              psel;
  logic              penable;
  logic [2:0]        pprot;
  logic              pwrite;
  logic [AWIDTH-1:0] paddr;
  logic [DBYTES-1:0] pstrb;
  logic [DWIDTH-1:0] pwdata;
  logic [DWIDTH-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport slave (
    input  hsel, hready, htrans, hsize, hprot, hwrite, haddr, hwdata,
    output hrdata, hreadyout, hresp,
    output psel, penable, pprot, pwrite, paddr, pstrb, pwdata,
    input  prdata, pready, pslverr
  );

  modport master (
    output hsel, hready, htrans, hsize, hprot, hwrite, haddr, hwdata,
    input  hrdata, hreadyout, hresp,
    input  psel, penable, pprot, pwrite, paddr, pstrb, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP+ACCESS per accepted AHB transfer,
// data phase stretched with hreadyout, pslverr and illegal transfers mapped to a two-cycle ERROR.
module ahb_apb_bridge #(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned DSIZE  = 2
) (
  input logic             hclk,
  input logic             hresetn,
  ahb_apb_bridge_if.slave bus
);
  localparam int unsigned DBYTES = 1 << DSIZE;
  localparam int unsigned DWIDTH = DBYTES * 8;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t            state_q;
  state_t            state_d;
  logic              psel_d;
  logic              penable_d;
  logic              hreadyout_d;
  logic              hresp_d;
  logic              accept;
  logic              load;
  logic              capture;
  logic              legal;
  logic [DBYTES-1:0] strb;
  int unsigned       offset;
  int unsigned       size_bytes;
  logic              unused_bits;

  assign accept      = bus.hsel & bus.hready & bus.htrans[1];
  assign bus.pwdata  = bus.hwdata;
  assign unused_bits = ^{bus.htrans[0], bus.hprot[3:2]};

  // Transfer legality (size fits the bus, address naturally aligned) and write byte strobes
  always_comb begin
    offset     = 32'(bus.haddr[DSIZE-1:0]);
    size_bytes = 32'd1 << bus.hsize;
    legal      = (32'(bus.hsize) <= DSIZE);
    for (int unsigned i = 0; i < DSIZE; i++) begin
      if ((i < 32'(bus.hsize)) && bus.haddr[i]) legal = 1'b0;
    end
    strb = '0;
    for (int unsigned i = 0; i < DBYTES; i++) begin
      strb[i] = bus.hwrite && (i >= offset) && (i < offset + size_bytes);
    end
  end

  // Next state, then registered outputs decoded from the state being entered
  always_comb begin
    state_d     = state_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    load        = 1'b0;
    capture     = 1'b0;

    case (state_q)
      IDLE, ERR2: begin
        state_d = IDLE;
        if (accept) begin
          load    = 1'b1;
          state_d = legal ? SETUP : ERR1;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          state_d = bus.pslverr ? ERR1 : IDLE;
          capture = !bus.pslverr && !bus.pwrite;
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase

    case (state_d)
      SETUP: begin
        psel_d      = 1'b1;
        hreadyout_d = 1'b0;
      end
      ACCESS: begin
        psel_d      = 1'b1;
        penable_d   = 1'b1;
        hreadyout_d = 1'b0;
      end
      ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      ERR2:    hresp_d = 1'b1;
      default: ;
    endcase
  end

  // State, handshake outputs and APB request / read-data registers
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q       <= IDLE;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.hreadyout <= 1'b1;
      bus.hresp     <= 1'b0;
      bus.hrdata    <= '0;
      bus.paddr     <= '0;
      bus.pstrb     <= '0;
      bus.pwrite    <= 1'b0;
      bus.pprot     <= '0;
    end else begin
      state_q       <= state_d;
      bus.psel      <= psel_d;
      bus.penable   <= penable_d;
      bus.hreadyout <= hreadyout_d;
      bus.hresp     <= hresp_d;
      if (load) begin
        bus.paddr  <= AWIDTH'(bus.haddr);
        bus.pwrite <= bus.hwrite;
        bus.pprot  <= {~bus.hprot[0], 1'b0, bus.hprot[1]};
        bus.pstrb  <= strb;
      end
      if (capture) bus.hrdata <= DWIDTH'(bus.prdata);
    end
  end
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Randomised bench for ahb_apb_bridge: drives AHB transfers, plays an APB RAM slave,
// and checks timing, responses and data against a transaction-level memory model.
module tb_ahb_apb_bridge;
  logic clk;
  logic rst_n;

  ahb_apb_bridge_if #(.AWIDTH(10), .DSIZE(2)) bus ();

  ahb_apb_bridge #(.AWIDTH(10), .DSIZE(2)) dut (
    .hclk   (clk),
    .hresetn(rst_n),
    .bus    (bus)
  );

  assign bus.hready = bus.hreadyout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // APB slave storage and the reference model's view of memory
  logic [31:0] ram       [256] = '{default: 32'h0};
  logic [31:0] mem_model [256] = '{default: 32'h0};
  logic [31:0] hrdata_exp = 32'h0;

  // Expectations for the transfer in flight, set by the driver
  int          stall_left  = 0;
  bit          err_resp    = 1'b0;
  int          psel_cycles = 0;
  logic [9:0]  exp_paddr   = '0;
  logic [3:0]  exp_pstrb   = '0;
  logic [2:0]  exp_pprot   = '0;
  bit          exp_pwrite  = 1'b0;
  logic [31:0] exp_pwdata  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_xfer(input logic [2:0] size, input logic [9:0] addr);
    if (size > 3'd2) return 1'b0;
    return (int'(addr) % (1 << size)) == 0;
  endfunction

  function automatic logic [3:0] strobe_of(input logic [2:0] size, input logic [9:0] addr);
    int unsigned nb;
    int unsigned m;
    nb = 1 << size;
    m  = ((1 << nb) - 1) << (int'(addr) % 4);
    return 4'(m);
  endfunction

  // APB slave: random wait states, optional error, byte-strobed RAM
  always @(negedge clk) begin
    if (!rst_n || !bus.psel) begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
    end else begin
      psel_cycles++;
      check("paddr", 32'(bus.paddr), 32'(exp_paddr));
      check("pstrb", 32'(bus.pstrb), 32'(exp_pstrb));
      check("pwrite", 32'(bus.pwrite), 32'(exp_pwrite));
      check("pprot", 32'(bus.pprot), 32'(exp_pprot));
      if (!bus.penable) begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
      end else begin
        if (bus.pwrite) check("pwdata", bus.pwdata, exp_pwdata);
        if (stall_left > 0) begin
          stall_left--;
          bus.pready  = 1'b0;
          bus.prdata  = $urandom;
        end else begin
          bus.pready  = 1'b1;
          bus.pslverr = err_resp;
          if (err_resp || bus.pwrite) begin
            bus.prdata = $urandom;
          end else begin
            bus.prdata = ram[bus.paddr[9:2]];
          end
          if (!err_resp && bus.pwrite) begin
            for (int b = 0; b < 4; b++) begin
              if (bus.pstrb[b]) ram[bus.paddr[9:2]][8*b +: 8] = bus.pwdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  task automatic arm(input bit w, input logic [2:0] size, input logic [9:0] addr,
                     input logic [31:0] data, input int stall, input bit err,
                     input logic [3:0] prot);
    exp_paddr   = addr;
    exp_pwrite  = w;
    exp_pstrb   = w ? strobe_of(size, addr) : 4'h0;
    exp_pprot   = {~prot[0], 1'b0, prot[1]};
    exp_pwdata  = data;
    stall_left  = stall;
    err_resp    = err;
    psel_cycles = 0;
  endtask

  task automatic addr_phase(input bit w, input logic [2:0] size, input logic [9:0] addr,
                            input logic [3:0] prot);
    bus.hsel   = 1'b1;
    bus.htrans = 2'b10;
    bus.hwrite = w;
    bus.hsize  = size;
    bus.haddr  = addr;
    bus.hprot  = prot;
  endtask

  task automatic bus_idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
  endtask

  // Wait out the data phase, check timing/response, then advance the model
  task automatic finish_xfer(input bit w, input logic [2:0] size, input logic [9:0] addr,
                             input logic [31:0] data, input int stall, input bit err);
    int   low;
    int   exp_low;
    bit   legal;
    bit   exp_err;
    logic resp_last;
    logic [3:0] m;
    legal     = legal_xfer(size, addr);
    exp_err   = !legal || err;
    exp_low   = !legal ? 1 : (2 + stall + (err ? 1 : 0));
    low       = 0;
    resp_last = 1'b0;
    while (low < 60) begin
      @(negedge clk);
      if (bus.hreadyout) break;
      low++;
      resp_last = bus.hresp;
    end
    check("wait_states", low, exp_low);
    check("hresp", 32'(bus.hresp), 32'(exp_err));
    if (exp_err) check("err1_hresp", 32'(resp_last), 32'd1);
    check("psel_cycles", psel_cycles, legal ? 2 + stall : 0);
    if (legal && !err) begin
      if (w) begin
        m = strobe_of(size, addr);
        for (int b = 0; b < 4; b++) begin
          if (m[b]) mem_model[addr[9:2]][8*b +: 8] = data[8*b +: 8];
        end
      end else begin
        hrdata_exp = mem_model[addr[9:2]];
      end
    end
    check("hrdata", bus.hrdata, hrdata_exp);
    if (exp_err) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("post_err_hresp", 32'(bus.hresp), 32'd0);
      check("post_err_ready", 32'(bus.hreadyout), 32'd1);
    end
  endtask

  task automatic do_xfer(input bit w, input logic [2:0] size, input logic [9:0] addr,
                         input logic [31:0] data, input int stall, input bit err,
                         input logic [3:0] prot);
    arm(w, size, addr, data, stall, err, prot);
    @(posedge clk); #1;
    addr_phase(w, size, addr, prot);
    @(posedge clk); #1;
    bus_idle();
    bus.hwdata = data;
    finish_xfer(w, size, addr, data, stall, err);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [2:0]  size;
    logic [9:0]  addr;
    logic [31:0] data;
    int unsigned off;
    bit          w;
    bit          err;
    int          stall;
    logic [3:0]  prot;

    rst_n      = 1'b0;
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'd0;
    bus.hprot  = 4'h0;
    bus.haddr  = '0;
    bus.hwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
    check("rst_hresp", 32'(bus.hresp), 32'd0);
    check("rst_psel", 32'(bus.psel), 32'd0);
    check("rst_penable", 32'(bus.penable), 32'd0);
    check("rst_hrdata", bus.hrdata, 32'd0);
    check("rst_paddr", 32'(bus.paddr), 32'd0);
    check("rst_pstrb", 32'(bus.pstrb), 32'd0);
    check("rst_pwrite", 32'(bus.pwrite), 32'd0);
    check("rst_pprot", 32'(bus.pprot), 32'd0);
    rst_n = 1'b1;

    // Word write, readback, byte merge
    do_xfer(1'b1, 3'd2, 10'h010, 32'hDEADBEEF, 0, 1'b0, 4'h3);
    do_xfer(1'b0, 3'd2, 10'h010, 32'h0, 0, 1'b0, 4'h1);
    check("rd_deadbeef", bus.hrdata, 32'hDEADBEEF);
    do_xfer(1'b1, 3'd2, 10'h00C, 32'hDEADBEEF, 0, 1'b0, 4'h0);
    do_xfer(1'b1, 3'd0, 10'h00D, 32'h0000AB00, 0, 1'b0, 4'h2);
    do_xfer(1'b0, 3'd2, 10'h00C, 32'h0, 0, 1'b0, 4'h0);
    check("rd_byte_merge", bus.hrdata, 32'hDEADABEF);

    // Stretched read, slave error, illegal transfers
    do_xfer(1'b0, 3'd2, 10'h010, 32'h0, 3, 1'b0, 4'h1);
    do_xfer(1'b0, 3'd2, 10'h00C, 32'h0, 0, 1'b1, 4'h1);
    check("slverr_hrdata_kept", bus.hrdata, 32'hDEADBEEF);
    do_xfer(1'b1, 3'd3, 10'h010, 32'h12345678, 0, 1'b0, 4'h0);
    do_xfer(1'b0, 3'd2, 10'h002, 32'h0, 0, 1'b0, 4'h0);

    // Reset in the middle of an ACCESS phase
    arm(1'b1, 3'd2, 10'h020, 32'hCAFEF00D, 6, 1'b0, 4'h0);
    @(posedge clk); #1;
    addr_phase(1'b1, 3'd2, 10'h020, 4'h0);
    @(posedge clk); #1;
    bus_idle();
    bus.hwdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_penable", 32'(bus.penable), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stall_left = 0;
    hrdata_exp = 32'h0;
    @(negedge clk);
    check("midrst_psel", 32'(bus.psel), 32'd0);
    check("midrst_penable", 32'(bus.penable), 32'd0);
    check("midrst_hreadyout", 32'(bus.hreadyout), 32'd1);
    check("midrst_hrdata", bus.hrdata, 32'd0);
    do_xfer(1'b1, 3'd2, 10'h020, 32'hCAFEF00D, 1, 1'b0, 4'h0);
    do_xfer(1'b0, 3'd2, 10'h020, 32'h0, 0, 1'b0, 4'h0);

    // Back-to-back: read pipelined into the completing cycle of a halfword write
    arm(1'b1, 3'd1, 10'h032, 32'h5A5A0000, 0, 1'b0, 4'h0);
    @(posedge clk); #1;
    addr_phase(1'b1, 3'd1, 10'h032, 4'h0);
    @(posedge clk); #1;
    addr_phase(1'b0, 3'd2, 10'h030, 4'h0);
    bus.hwdata = 32'h5A5A0000;
    finish_xfer(1'b1, 3'd1, 10'h032, 32'h5A5A0000, 0, 1'b0);
    arm(1'b0, 3'd2, 10'h030, 32'h0, 0, 1'b0, 4'h0);
    @(posedge clk); #1;
    bus_idle();
    finish_xfer(1'b0, 3'd2, 10'h030, 32'h0, 0, 1'b0);

    // Random traffic over a small window so reads hit earlier writes
    for (int n = 0; n < 200; n++) begin
      w     = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      off   = $urandom_range(0, 3);
      if (size <= 3'd2 && $urandom_range(0, 4) != 0) off = off & ~((32'd1 << size) - 1);
      addr  = {6'($urandom_range(0, 15)), 2'(off)};
      addr  = addr + 10'h040;
      data  = $urandom;
      stall = $urandom_range(0, 3);
      err   = ($urandom_range(0, 7) == 0);
      prot  = 4'($urandom_range(0, 15));
      do_xfer(w, size, addr, data, stall, err, prot);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
